// File: rtl/vga_pkg.sv
// Shared constants, colour encoding and clear-FSM state type for the VGA cell renderer.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE   = 10'd640;
  localparam logic [8:0] V_ACTIVE   = 9'd480;
  localparam int         CELL_COLS  = 80;
  localparam int         CELL_ROWS  = 60;
  localparam int         CELL_COUNT = 4800;

  typedef logic [2:0] color_t;  // {R,G,B}

  localparam color_t BLACK = 3'b000;
  localparam color_t WHITE = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_t;

  // row*80 + col as x64 + x16 shift-add; 13 bits covers even off-screen counts
  function automatic logic [12:0] cell_index(input logic [5:0] cell_row,
                                             input logic [6:0] cell_col);
    logic [12:0] row_w;
    row_w = {7'd0, cell_row};
    return (row_w << 6) + (row_w << 4) + {6'd0, cell_col};
  endfunction

endpackage

// File: rtl/vga_cell_ram.sv
// Cell framebuffer: one write port and one synchronous read port, no reset (block-RAM style).
module vga_cell_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = CELL_COUNT
) (
  input  logic        Clock,
  input  logic        we,
  input  logic [12:0] waddr,
  input  color_t      wdata,
  input  logic [12:0] raddr,
  output color_t      rdata
);

  color_t mem_r [DEPTH];

  // Write port plus registered read; a same-edge read returns the old contents
  always_ff @(posedge Clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/vga_cell_renderer.sv
// 3-stage cell-colour pixel pipeline with pixel-aligned syncs and a full-screen clear engine.
// Optional build macro: VGA_BORDER_EN forces a white one-pixel frame around the active area.
module vga_cell_renderer
  import vga_pkg::*;
#(
  parameter int PIPE_LAT   = 3,
  parameter int CELL_COUNT = CELL_COLS * CELL_ROWS
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [9:0]  column_count,
  input  logic [8:0]  row_count,
  input  logic        iHSYNC,
  input  logic        iVSYNC,
  input  logic        wr_en,
  input  logic [12:0] wr_addr,
  input  logic [2:0]  wr_data,
  input  logic        clear_req,
  input  logic [2:0]  clear_color,
  output logic        busy,
  output logic        VGA_RED,
  output logic        VGA_GREEN,
  output logic        VGA_BLUE,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC
);

  logic [12:0]         addr_s1_r;
  logic                active_s1_r;
  logic                active_s2_r;
  color_t              rd_data_s;
  color_t              rgb_r;
  logic [PIPE_LAT-1:0] hsync_pipe_r;
  logic [PIPE_LAT-1:0] vsync_pipe_r;
  clear_state_t        state_r;
  logic [12:0]         clear_addr_r;
  color_t              clear_color_r;
  logic                busy_r;
  logic                ram_we_s;
  logic [12:0]         ram_waddr_s;
  color_t              ram_wdata_s;
`ifdef VGA_BORDER_EN
  logic [9:0]          col_s1_r;
  logic [9:0]          col_s2_r;
  logic [8:0]          row_s1_r;
  logic [8:0]          row_s2_r;
  logic                border_s;
`endif

  // S1: cell address and active-area flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_s1_r   <= 13'd0;
      active_s1_r <= 1'b0;
    end else begin
      addr_s1_r   <= cell_index(row_count[8:3], column_count[9:3]);
      active_s1_r <= (column_count < H_ACTIVE) && (row_count < V_ACTIVE);
    end
  end

  // S2: RAM read happens inside the RAM; carry the active flag alongside it
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      active_s2_r <= 1'b0;
    end else begin
      active_s2_r <= active_s1_r;
    end
  end

`ifdef VGA_BORDER_EN
  // Pixel coordinates ride with the data so S3 can detect the frame edge
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      col_s1_r <= 10'd0;
      row_s1_r <= 9'd0;
      col_s2_r <= 10'd0;
      row_s2_r <= 9'd0;
    end else begin
      col_s1_r <= column_count;
      row_s1_r <= row_count;
      col_s2_r <= col_s1_r;
      row_s2_r <= row_s1_r;
    end
  end

  // Outermost active rows and columns
  always_comb begin
    border_s = (col_s2_r == 10'd0) || (col_s2_r == H_ACTIVE - 10'd1) ||
               (row_s2_r == 9'd0)  || (row_s2_r == V_ACTIVE - 9'd1);
  end
`endif

  // S3: registered colour, blanked outside the active area
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rgb_r <= BLACK;
    end else if (!active_s2_r) begin
      rgb_r <= BLACK;
`ifdef VGA_BORDER_EN
    end else if (border_s) begin
      rgb_r <= WHITE;
`endif
    end else begin
      rgb_r <= rd_data_s;
    end
  end

  // Sync delay line, same depth as the pixel path; resets to inactive-high
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hsync_pipe_r <= {PIPE_LAT{1'b1}};
      vsync_pipe_r <= {PIPE_LAT{1'b1}};
    end else begin
      hsync_pipe_r <= {hsync_pipe_r[PIPE_LAT-2:0], iHSYNC};
      vsync_pipe_r <= {vsync_pipe_r[PIPE_LAT-2:0], iVSYNC};
    end
  end

  // Clear engine: one cell per cycle from 0 to CELL_COUNT-1
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r       <= IDLE;
      clear_addr_r  <= 13'd0;
      clear_color_r <= BLACK;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (clear_req) begin
            clear_color_r <= clear_color;
            clear_addr_r  <= 13'd0;
            busy_r        <= 1'b1;
            state_r       <= CLEAR;
          end
        end
        CLEAR: begin
          if (clear_addr_r == 13'(CELL_COUNT - 1)) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            clear_addr_r <= clear_addr_r + 13'd1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Write-port arbitration: the clear engine owns the port; user writes only in IDLE
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = wr_addr;
    ram_wdata_s = wr_data;
    if (state_r == CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clear_addr_r;
      ram_wdata_s = clear_color_r;
    end else begin
      ram_we_s = wr_en && (wr_addr < 13'(CELL_COUNT));
    end
  end

  vga_cell_ram #(
    .DEPTH (CELL_COUNT)
  ) u_ram (
    .Clock (Clock),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (addr_s1_r),
    .rdata (rd_data_s)
  );

  assign busy      = busy_r;
  assign VGA_RED   = rgb_r[2];
  assign VGA_GREEN = rgb_r[1];
  assign VGA_BLUE  = rgb_r[0];
  assign VGA_HSYNC = hsync_pipe_r[PIPE_LAT-1];
  assign VGA_VSYNC = vsync_pipe_r[PIPE_LAT-1];

endmodule

// File: tb/tb_vga_cell_renderer.sv
// Self-checking bench for vga_cell_renderer: vector table plus scoreboard of delayed pixel/sync values.
// Honours VGA_BORDER_EN so the same bench covers both builds.
module tb_vga_cell_renderer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [9:0]  column_count;
  logic [8:0]  row_count;
  logic        iHSYNC, iVSYNC;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [2:0]  wr_data;
  logic        clear_req;
  logic [2:0]  clear_color;
  logic        busy;
  logic        VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC;

`ifdef VGA_BORDER_EN
  localparam bit BORDER_BUILD = 1'b1;
`else
  localparam bit BORDER_BUILD = 1'b0;
`endif

  always #5 Clock = ~Clock;

  vga_cell_renderer #(.PIPE_LAT(3), .CELL_COUNT(4800)) dut (
    .Clock(Clock), .Reset(Reset),
    .column_count(column_count), .row_count(row_count),
    .iHSYNC(iHSYNC), .iVSYNC(iVSYNC),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .clear_color(clear_color),
    .busy(busy),
    .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE),
    .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [2:0] model_mem [4800];

  typedef struct {
    int         due;
    logic [9:0] col;
    logic [8:0] row;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } sb_t;
  sb_t sb_q[$];
  sb_t cur;

  typedef struct {
    logic [9:0] col;
    logic [8:0] row;
    logic [2:0] rgb;
  } vec_t;
  vec_t vecs[15];

  always @(posedge Clock) cyc <= cyc + 1;

  // Scoreboard: compare outputs that fall due on this cycle
  always @(negedge Clock) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      cur = sb_q.pop_front();
      checks++;
      if (cur.due != cyc || {VGA_RED, VGA_GREEN, VGA_BLUE} !== cur.rgb ||
          VGA_HSYNC !== cur.hs || VGA_VSYNC !== cur.vs) begin
        errors++;
        $display("FAIL pix(%0d,%0d) due %0d at %0d: rgb=%b hs=%b vs=%b, expected rgb=%b hs=%b vs=%b",
                 cur.col, cur.row, cur.due, cyc, {VGA_RED, VGA_GREEN, VGA_BLUE},
                 VGA_HSYNC, VGA_VSYNC, cur.rgb, cur.hs, cur.vs);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] with_border(input logic [9:0] c, input logic [8:0] r,
                                             input logic [2:0] rgb);
    if (BORDER_BUILD && c < 640 && r < 480 && (c == 0 || c == 639 || r == 0 || r == 479))
      return 3'b111;
    return rgb;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic [9:0] c, input logic [8:0] r, input logic hs, input logic vs,
                       input logic [2:0] rgb);
    sb_t e;
    column_count = c;
    row_count    = r;
    iHSYNC       = hs;
    iVSYNC       = vs;
    e.due = cyc + 3;
    e.col = c;
    e.row = r;
    e.rgb = with_border(c, r, rgb);
    e.hs  = hs;
    e.vs  = vs;
    sb_q.push_back(e);
    step(1);
  endtask

  task automatic scan_cell(input int idx, input logic [2:0] exp);
    drive(10'((idx % 80) * 8 + 3), 9'((idx / 80) * 8 + 5), 1'b1, 1'b1, exp);
  endtask

  task automatic write_cell(input logic [12:0] a, input logic [2:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step(1);
    wr_en = 1'b0;
    if (a < 13'd4800) model_mem[a] = d;
  endtask

  // Runs a clear; optionally injects a write to cell 5 or aborts by reset at busy-cycle abort_at
  task automatic do_clear(input logic [2:0] color, input int inject_at, input int abort_at,
                          output int n);
    bit aborted;
    aborted     = 1'b0;
    clear_req   = 1'b1;
    clear_color = color;
    step(1);
    clear_req   = 1'b0;
    clear_color = ~color;
    n = 0;
    while (busy === 1'b1 && n < 6000 && !aborted) begin
      n++;
      if (n == inject_at) begin
        wr_en = 1'b1; wr_addr = 13'd5; wr_data = 3'b111;
      end else begin
        wr_en = 1'b0;
      end
      if (n == abort_at) begin
        Reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hsync", 32'(VGA_HSYNC), 32'd1);
        chk("abort_vsync", 32'(VGA_VSYNC), 32'd1);
        chk("abort_rgb", 32'({VGA_RED, VGA_GREEN, VGA_BLUE}), 32'd0);
        step(1);
        Reset = 1'b0;
        for (int i = 0; i < n - 1; i++) model_mem[i] = color;
        aborted = 1'b1;
      end else begin
        step(1);
      end
    end
    wr_en = 1'b0;
    if (!aborted) begin
      for (int i = 0; i < 4800; i++) model_mem[i] = color;
    end
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    column_count = 10'd0; row_count = 9'd0;
    iHSYNC = 1'b0; iVSYNC = 1'b0;
    wr_en = 1'b0; wr_addr = 13'd0; wr_data = 3'd0;
    clear_req = 1'b0; clear_color = 3'd0;
    step(3);
    chk("reset_rgb", 32'({VGA_RED, VGA_GREEN, VGA_BLUE}), 32'd0);
    chk("reset_hsync", 32'(VGA_HSYNC), 32'd1);
    chk("reset_vsync", 32'(VGA_VSYNC), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    Reset = 1'b0;
    iHSYNC = 1'b1; iVSYNC = 1'b1;
    step(2);

    do_clear(3'b000, 0, 0, n);
    chk("clear_len_black", 32'(n), 32'd4800);

    // Border pixels over an all-black frame (white only in the border build)
    drive(10'd0,   9'd240, 1'b1, 1'b1, 3'b000);
    drive(10'd639, 9'd240, 1'b1, 1'b1, 3'b000);
    drive(10'd320, 9'd0,   1'b1, 1'b1, 3'b000);
    drive(10'd320, 9'd479, 1'b1, 1'b1, 3'b000);
    drive(10'd1,   9'd1,   1'b1, 1'b1, 3'b000);

    write_cell(13'd0, 3'b100);
    write_cell(13'd81, 3'b010);
    vecs[0]  = '{10'd0,    9'd0,   3'b100};
    vecs[1]  = '{10'd7,    9'd7,   3'b100};
    vecs[2]  = '{10'd3,    9'd5,   3'b100};
    vecs[3]  = '{10'd8,    9'd8,   3'b010};
    vecs[4]  = '{10'd15,   9'd15,  3'b010};
    vecs[5]  = '{10'd12,   9'd9,   3'b010};
    vecs[6]  = '{10'd8,    9'd7,   3'b000};
    vecs[7]  = '{10'd16,   9'd8,   3'b000};
    vecs[8]  = '{10'd7,    9'd8,   3'b000};
    vecs[9]  = '{10'd639,  9'd479, 3'b000};
    vecs[10] = '{10'd700,  9'd10,  3'b000};
    vecs[11] = '{10'd10,   9'd490, 3'b000};
    vecs[12] = '{10'd1023, 9'd511, 3'b000};
    vecs[13] = '{10'd640,  9'd0,   3'b000};
    vecs[14] = '{10'd0,    9'd480, 3'b000};
    for (int i = 0; i < 15; i++) drive(vecs[i].col, vecs[i].row, 1'b1, 1'b1, vecs[i].rgb);
    step(4);

    // Clear to 001 with a dropped write to cell 5 mid-clear, then scan every cell
    do_clear(3'b001, 10, 0, n);
    chk("clear_len_001", 32'(n), 32'd4800);
    scan_cell(5, 3'b001);
    for (int i = 0; i < 4800; i++) scan_cell(i, model_mem[i]);

    // Blanking over non-zero RAM, and sync pulses delayed with their width preserved
    drive(10'd700, 9'd10,  1'b1, 1'b1, 3'b000);
    drive(10'd10,  9'd490, 1'b1, 1'b1, 3'b000);
    drive(10'd700, 9'd10,  1'b0, 1'b1, 3'b000);
    drive(10'd700, 9'd10,  1'b0, 1'b0, 3'b000);
    drive(10'd700, 9'd10,  1'b0, 1'b1, 3'b000);
    drive(10'd700, 9'd10,  1'b1, 1'b1, 3'b000);
    drive(10'd700, 9'd10,  1'b1, 1'b1, 3'b000);

    // Out-of-range write is dropped
    write_cell(13'd4800, 3'b111);
    scan_cell(0, 3'b001);
    scan_cell(4799, 3'b001);
    step(4);

    // Reset 100 cycles into a clear, then a full clear afterwards
    iHSYNC = 1'b0; iVSYNC = 1'b0;
    step(4);
    do_clear(3'b110, 0, 100, n);
    chk("abort_point", 32'(n), 32'd100);
    step(2);
    scan_cell(0, 3'b110);
    scan_cell(98, 3'b110);
    scan_cell(99, 3'b001);
    scan_cell(200, 3'b001);
    step(4);
    do_clear(3'b010, 0, 0, n);
    chk("clear_len_after_reset", 32'(n), 32'd4800);
    scan_cell(0, 3'b010);
    scan_cell(2400, 3'b010);
    scan_cell(4799, 3'b010);
    step(5);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_cell_renderer.md
# vga_cell_renderer

Pixel-colour stage directly downstream of the VGA timing generator. Consumes its `column_count`/`row_count` and raw sync outputs. Looks up a 3-bit colour per 8x8-pixel cell in an 80x60 cell framebuffer, which is written by the MiniAlu. Drives `VGA_RED`/`VGA_GREEN`/`VGA_BLUE` and delays the syncs so they stay pixel-aligned with the colour outputs. Includes a hardware clear engine that fills the whole framebuffer with one colour.

## Interface
Parameters:
- `PIPE_LAT`, 3: pixel pipeline depth in cycles. Fixed; it is a parameter only for the bench.
- `CELL_COUNT`, 4800: number of framebuffer cells (80 x 60).

Ports (one clock; reset is asynchronous and active-high):
- `Clock` in 1: pixel clock.
- `Reset` in 1: asynchronous, active-high reset.
- `column_count` in 10: current pixel column from the timing generator.
- `row_count` in 9: current pixel row from the timing generator.
- `iHSYNC` in 1: raw horizontal sync, active-low.
- `iVSYNC` in 1: raw vertical sync, active-low.
- `wr_en` in 1: single-cycle cell write strobe.
- `wr_addr` in 13: cell index, computed as row*80 + col.
- `wr_data` in 3: cell colour {R,G,B}.
- `clear_req` in 1: pulse that starts a full-screen clear.
- `clear_color` in 3: fill colour, sampled on the cycle `clear_req` is accepted.
- `busy` out 1: high while a clear is in progress.
- `VGA_RED` out 1: red pixel output.
- `VGA_GREEN` out 1: green pixel output.
- `VGA_BLUE` out 1: blue pixel output.
- `VGA_HSYNC` out 1: `iHSYNC` delayed by `PIPE_LAT` cycles.
- `VGA_VSYNC` out 1: `iVSYNC` delayed by `PIPE_LAT` cycles.

## Operation
Pixel pipeline:
- S1 registers the cell address, (`row_count[8:3]`*80) + `column_count[9:3]`. The *80 is implemented as shift-add (x64 + x16). The address is 13 bits.
- S1 also registers the active flag, (`column_count` < 640) && (`row_count` < 480), and the pixel coordinates.
- S2 performs a synchronous RAM read.
- S3 registers the output:
  - RGB = cell colour if the pixel is active, else 3'b000.
- The sync signals pass through a 3-deep shift register alongside the pixel data.

Write port:
- When `wr_en`=1, `wr_addr` < 4800 and the engine is in IDLE, the cell is written on that edge.
- `wr_addr` >= 4800 is silently dropped.
- Any write arriving while `busy`=1 is dropped.

Clear FSM (two states):
- IDLE: when `clear_req`=1, latch `clear_color`, set addr=0, go to CLEAR. `busy` rises on the next cycle.
- CLEAR: write the latched colour to addr on every cycle and increment addr. When addr==4799, write it and return to IDLE; `busy` falls on the following cycle.
- `clear_req` is ignored while in CLEAR.
- A clear takes exactly 4800 cycles.
- The display read port keeps running during a clear, so partially cleared frames are legal.

## Timing
- Reset values:
  - `VGA_RED`/`VGA_GREEN`/`VGA_BLUE` = 0.
  - `VGA_HSYNC`/`VGA_VSYNC` = 1 (inactive), including all sync pipe stages.
  - `busy` = 0, FSM = IDLE, clear address = 0.
- RAM contents are not reset and are undefined until cleared.
- Latency: the pixel at count (c,r) on edge N appears on RGB at edge N+3, and its syncs at N+3.
- Write-to-display: a cell written on edge N is visible for reads sampled in S2 at edge N+1 or later (read-after-write, no bypass required).
- Reset asserted during CLEAR: the clear aborts immediately, `busy` = 0, partial fill remains in RAM.
- Simultaneous `wr_en` and `clear_req` in IDLE: the write completes on that edge and the clear starts next cycle.

## Configuration
- `VGA_BORDER_EN` defined: in S3, active pixels with column 0 or 639, or row 0 or 479, are forced to 3'b111, overriding the cell colour.
- `VGA_BORDER_EN` undefined: no border logic; RGB is the cell colour or blank.
- Latency is identical in both builds.

## Structure
- Shared package `vga_pkg` holds:
  - constants H_ACTIVE=640, V_ACTIVE=480, CELL_COLS=80, CELL_ROWS=60, CELL_COUNT=4800;
  - the colour encoding {R,G,B} with names BLACK=3'b000 and WHITE=3'b111;
  - the FSM state typedef {IDLE, CLEAR}.
- Sub-module `vga_cell_ram`: 4800x3 RAM, one write port and one synchronous read port on `Clock`, no reset, inferable as block RAM.

## Test plan
- Reset, then write cell 0 = 3'b100 and cell 81 = 3'b010. Scan pixels: (0,0)-(7,7) give RGB=100; (8,8)-(15,15) give RGB=010; every other pixel reads its cleared value. All RGB appears exactly 3 cycles after the counts.
- `clear_req` with `clear_color`=3'b001 → `busy` high for 4800 cycles. Afterwards every active pixel is 001. A `wr_en` to cell 5 during the clear is dropped (cell 5 reads 001).
- `column_count`=700 or `row_count`=490 → RGB=000 regardless of RAM contents. `iHSYNC` low pulse → `VGA_HSYNC` low pulse delayed by 3 cycles, same width.
- `wr_addr`=4800 with `wr_data`=3'b111 → no RAM change (cell 0 and cell 4799 unchanged).
- Assert `Reset` 100 cycles into a clear → `busy`=0 and syncs=1 immediately. After release, a new `clear_req` runs the full 4800 cycles.
- With `VGA_BORDER_EN` defined and all cells 000 → pixels (0,240), (639,240), (320,0), (320,479) give 111, and (1,1) gives 000.
